// File: rtl/align_batch_scheduler.sv
// Batch sequencer ahead of the MAC aligner: collects up to NUM_PP partial products with a
// running max exponent, replays them back-to-back tagged with the batch max, then waits out the aligner.
module align_batch_scheduler #(
  parameter int unsigned NUM_PP    = 8,
  parameter int unsigned ALIGN_LAT = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [3:0]                i_denorm_pp,
  input  logic [5:0]                i_exp,
  input  logic                      i_last,
  input  logic [4:0]                i_Q_frac,
  output logic                      o_valid,
  output logic [3:0]                o_denorm_pp,
  output logic [5:0]                o_exp,
  output logic [5:0]                o_max_exp,
  output logic [4:0]                o_Q_frac,
  output logic                      o_last,
  output logic                      o_batch_done,
  output logic [$clog2(NUM_PP):0]   o_count
);

  localparam int unsigned AW = $clog2(NUM_PP);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = $clog2(ALIGN_LAT + 1);

  typedef enum logic [1:0] {S_COLLECT, S_ISSUE, S_DRAIN} state_t;

  state_t          r_state, w_state;
  logic [AW-1:0]   r_wptr, w_wptr, r_rptr, w_rptr;
  logic [5:0]      r_max, w_max;
  logic [CW-1:0]   r_count, w_count;
  logic [DW-1:0]   r_drain, w_drain;
  logic [4:0]      r_qfrac, w_qfrac;
  logic            r_ready, w_ready, r_valid, w_valid, r_last, w_last, r_done, w_done;
  logic [3:0]      r_pp, w_pp;
  logic [5:0]      r_exp, w_exp;
  logic [3:0]      r_buf_pp  [NUM_PP];
  logic [5:0]      r_buf_exp [NUM_PP];

  logic            w_accept, w_first, w_finish;
  logic [5:0]      w_max_upd;

  assign w_accept  = (r_state == S_COLLECT) && r_ready && i_valid;
  assign w_first   = (r_wptr == '0);
  assign w_max_upd = (w_first || (i_exp > r_max)) ? i_exp : r_max;

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    w_state  = r_state;
    w_wptr   = r_wptr;
    w_rptr   = r_rptr;
    w_max    = r_max;
    w_count  = r_count;
    w_drain  = r_drain;
    w_qfrac  = r_qfrac;
    w_ready  = 1'b0;
    w_valid  = 1'b0;
    w_pp     = '0;
    w_exp    = '0;
    w_last   = 1'b0;
    w_done   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_COLLECT: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_wptr  = r_wptr + AW'(1);
          w_count = w_first ? CW'(1) : r_count + CW'(1);
          w_max   = w_max_upd;
          if (w_first) w_qfrac = i_Q_frac;
          // Closing entry: launch beat 0 on this same edge (bypass when it is the only entry)
          if (i_last || (r_wptr == AW'(NUM_PP - 1))) begin
            w_state = S_ISSUE;
            w_ready = 1'b0;
            w_valid = 1'b1;
            w_pp    = w_first ? i_denorm_pp : r_buf_pp[0];
            w_exp   = w_first ? i_exp : r_buf_exp[0];
            w_last  = w_first;
            w_rptr  = AW'(1);
          end
        end
      end
      S_ISSUE: begin
        if (r_last) begin
          if (ALIGN_LAT == 1) begin
            w_finish = 1'b1;
          end else begin
            w_state = S_DRAIN;
            w_drain = DW'(ALIGN_LAT - 1);
          end
        end else begin
          w_valid = 1'b1;
          w_pp    = r_buf_pp[r_rptr];
          w_exp   = r_buf_exp[r_rptr];
          w_last  = (CW'(r_rptr) == (r_count - CW'(1)));
          w_rptr  = r_rptr + AW'(1);
        end
      end
      S_DRAIN: begin
        w_drain = r_drain - DW'(1);
        if (w_drain == '0) w_finish = 1'b1;
      end
      default: w_state = S_COLLECT;
    endcase
    // Last beat has cleared the aligner: reopen for the next batch
    if (w_finish) begin
      w_state = S_COLLECT;
      w_done  = 1'b1;
      w_ready = 1'b1;
      w_wptr  = '0;
      w_rptr  = '0;
      w_max   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_COLLECT;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_max   <= '0;
      r_count <= '0;
      r_drain <= '0;
      r_qfrac <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_pp    <= '0;
      r_exp   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_wptr  <= w_wptr;
      r_rptr  <= w_rptr;
      r_max   <= w_max;
      r_count <= w_count;
      r_drain <= w_drain;
      r_qfrac <= w_qfrac;
      r_ready <= w_ready;
      r_valid <= w_valid;
      r_pp    <= w_pp;
      r_exp   <= w_exp;
      r_last  <= w_last;
      r_done  <= w_done;
    end
  end

  // Entry storage; contents are only meaningful below the write pointer
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_buf_pp[r_wptr]  <= i_denorm_pp;
      r_buf_exp[r_wptr] <= i_exp;
    end
  end

  assign o_ready      = r_ready;
  assign o_valid      = r_valid;
  assign o_denorm_pp  = r_pp;
  assign o_exp        = r_exp;
  assign o_max_exp    = r_max;
  assign o_Q_frac     = r_qfrac;
  assign o_last       = r_last;
  assign o_batch_done = r_done;
  assign o_count      = r_count;

endmodule

// File: tb/tb_align_batch_scheduler.sv
// Bench for align_batch_scheduler: two instances (aligner latency 1 and 3) driven with
// directed and random batches, checked against a transaction-level expectation of each batch.
module tb_align_batch_scheduler;

  localparam int unsigned NUM_PP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   [2];
  logic       valid_i [2];
  logic [3:0] pp_i    [2];
  logic [5:0] exp_i   [2];
  logic       last_i  [2];
  logic [4:0] q_i     [2];
  logic       ready_o [2];
  logic       valid_o [2];
  logic [3:0] pp_o    [2];
  logic [5:0] exp_o   [2];
  logic [5:0] max_o   [2];
  logic [4:0] q_o     [2];
  logic       last_o  [2];
  logic       done_o  [2];
  logic [3:0] cnt_o   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    align_batch_scheduler #(.NUM_PP(NUM_PP), .ALIGN_LAT((g == 0) ? 1 : 3)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n[g]),
      .i_valid     (valid_i[g]),
      .o_ready     (ready_o[g]),
      .i_denorm_pp (pp_i[g]),
      .i_exp       (exp_i[g]),
      .i_last      (last_i[g]),
      .i_Q_frac    (q_i[g]),
      .o_valid     (valid_o[g]),
      .o_denorm_pp (pp_o[g]),
      .o_exp       (exp_o[g]),
      .o_max_exp   (max_o[g]),
      .o_Q_frac    (q_o[g]),
      .o_last      (last_o[g]),
      .o_batch_done(done_o[g]),
      .o_count     (cnt_o[g])
    );
  end

  int         n_checks = 0;
  int         n_errors = 0;
  int         prev_cnt [2];
  bit         in_done;
  logic [3:0] b_pp  [16];
  logic [5:0] b_exp [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      b_exp[i] = 6'($urandom_range(0, 63));
      b_pp[i]  = {1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3))};
    end
  endtask

  task automatic idle_inputs(input int d);
    valid_i[d] = 1'b0;
    pp_i[d]    = '0;
    exp_i[d]   = '0;
    last_i[d]  = 1'b0;
    q_i[d]     = '0;
  endtask

  // One batch from first offer to done pulse; chain leaves us inside the done cycle
  task automatic run_batch(input int d, input int n, input bit use_last, input logic [4:0] qf,
                           input logic [4:0] qr, input bit chain, input int abort);
    int         lat;
    logic [5:0] mx;
    lat = (d == 0) ? 1 : 3;
    mx  = b_exp[0];
    for (int i = 1; i < n; i++) if (b_exp[i] > mx) mx = b_exp[i];

    for (int k = 0; k < n; k++) begin
      if (!(k == 0 && in_done)) begin
        @(negedge clk);
        check("ready_collect", 32'(ready_o[d]), 32'd1);
        check("valid_collect", 32'(valid_o[d]), 32'd0);
        check("done_collect", 32'(done_o[d]), 32'd0);
        check("count_collect", 32'(cnt_o[d]), (k == 0) ? 32'(prev_cnt[d]) : 32'(k));
      end
      valid_i[d] = 1'b1;
      pp_i[d]    = b_pp[k];
      exp_i[d]   = b_exp[k];
      last_i[d]  = use_last && (k == n - 1);
      q_i[d]     = (k == 0) ? qf : qr;
      @(posedge clk); #1;
    end
    in_done = 1'b0;

    // Upstream keeps offering a poisoned entry that must never be taken
    valid_i[d] = 1'b1;
    pp_i[d]    = 4'hF;
    exp_i[d]   = 6'h3F;
    last_i[d]  = 1'b1;
    q_i[d]     = 5'h1F;

    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("beat_valid", 32'(valid_o[d]), 32'd1);
      check("beat_pp", 32'(pp_o[d]), 32'(b_pp[k]));
      check("beat_exp", 32'(exp_o[d]), 32'(b_exp[k]));
      check("beat_max", 32'(max_o[d]), 32'(mx));
      check("beat_q", 32'(q_o[d]), 32'(qf));
      check("beat_last", 32'(last_o[d]), (k == n - 1) ? 32'd1 : 32'd0);
      check("beat_ready", 32'(ready_o[d]), 32'd0);
      check("beat_count", 32'(cnt_o[d]), 32'(n));
      check("beat_done", 32'(done_o[d]), 32'd0);
      if (k == abort) begin
        rst_n[d] = 1'b0;
        idle_inputs(d);
        #1;
        check("rst_valid", 32'(valid_o[d]), 32'd0);
        check("rst_last", 32'(last_o[d]), 32'd0);
        check("rst_ready", 32'(ready_o[d]), 32'd1);
        check("rst_done", 32'(done_o[d]), 32'd0);
        check("rst_count", 32'(cnt_o[d]), 32'd0);
        check("rst_max", 32'(max_o[d]), 32'd0);
        check("rst_exp", 32'(exp_o[d]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_hold_done", 32'(done_o[d]), 32'd0);
        check("rst_hold_valid", 32'(valid_o[d]), 32'd0);
        rst_n[d] = 1'b1;
        @(posedge clk); #1;
        prev_cnt[d] = 0;
        return;
      end
      @(posedge clk); #1;
    end

    for (int j = 1; j < lat; j++) begin
      @(negedge clk);
      check("drain_valid", 32'(valid_o[d]), 32'd0);
      check("drain_ready", 32'(ready_o[d]), 32'd0);
      check("drain_done", 32'(done_o[d]), 32'd0);
      @(posedge clk); #1;
    end

    @(negedge clk);
    check("done_pulse", 32'(done_o[d]), 32'd1);
    check("done_ready", 32'(ready_o[d]), 32'd1);
    check("done_valid", 32'(valid_o[d]), 32'd0);
    check("done_count", 32'(cnt_o[d]), 32'(n));
    idle_inputs(d);
    prev_cnt[d] = n;
    if (chain) in_done = 1'b1;
    else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  ul;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      idle_inputs(d);
      prev_cnt[d] = 0;
    end
    in_done = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", 32'(ready_o[d]), 32'd1);
      check("reset_valid", 32'(valid_o[d]), 32'd0);
      check("reset_count", 32'(cnt_o[d]), 32'd0);
      check("reset_done", 32'(done_o[d]), 32'd0);
      check("reset_max", 32'(max_o[d]), 32'd0);
      check("reset_q", 32'(q_o[d]), 32'd0);
      check("reset_last", 32'(last_o[d]), 32'd0);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      in_done = 1'b0;
      // Directed four-entry batch
      b_exp[0] = 6'd3; b_exp[1] = 6'd7; b_exp[2] = 6'd5; b_exp[3] = 6'd7;
      b_pp[0]  = 4'h4; b_pp[1]  = 4'hC; b_pp[2]  = 4'h5; b_pp[3]  = 4'h7;
      run_batch(d, 4, 1'b1, 5'd2, 5'd2, 1'b0, -1);
      // Forced close at NUM_PP without i_last
      fill_random(NUM_PP);
      run_batch(d, NUM_PP, 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, -1);
      // Single entry at the exponent ceiling, next batch offered in the done cycle
      b_exp[0] = 6'd63; b_pp[0] = 4'hD;
      run_batch(d, 1, 1'b1, 5'd7, 5'd7, 1'b1, -1);
      b_exp[0] = 6'd2; b_pp[0] = 4'h6;
      run_batch(d, 1, 1'b1, 5'd11, 5'd11, 1'b0, -1);
      // Q_frac sampled on the first entry only
      fill_random(5);
      run_batch(d, 5, 1'b1, 5'd3, 5'd9, 1'b0, -1);
      // Reset during beat 2 of 4, then a fresh batch
      fill_random(4);
      run_batch(d, 4, 1'b1, 5'd5, 5'd5, 1'b0, 1);
      fill_random(3);
      run_batch(d, 3, 1'b1, 5'd12, 5'd20, 1'b0, -1);
      // Random batches, sometimes chained into the done cycle
      for (int r = 0; r < 10; r++) begin
        n  = $urandom_range(1, NUM_PP);
        ul = (n < NUM_PP) ? 1'b1 : 1'($urandom_range(0, 1));
        fill_random(n);
        run_batch(d, n, ul, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  (r < 9) ? 1'($urandom_range(0, 1)) : 1'b0, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/align_batch_scheduler.md
Name: align_batch_scheduler

Overview:
- Front-end sequencer for the MAC alignment stage.
- Collects one batch of denormalised partial products and their exponents, tracking the running maximum exponent.
- Then issues the entries back-to-back to the aligner, one per cycle, each tagged with the batch max_exp and Q_frac.
- Waits out the aligner pipeline latency, pulses batch-done, and reopens for the next batch.

Parameters:
- NUM_PP, 8, maximum entries per batch (power of two, 2..16)
- ALIGN_LAT, 1, aligner pipeline depth in cycles, counted from the scheduler output to the aligner output valid (1..4)

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  reset; asynchronous assert, active-low
- i_valid  input  1  upstream entry valid
- o_ready  output  1  scheduler accepts an entry this cycle
- i_denorm_pp  input  4  {sign, leading one, 2 fraction bits}
- i_exp  input  6  unsigned exponent of the entry
- i_last  input  1  entry closes the batch
- i_Q_frac  input  5  batch fraction format; sampled on the first entry of a batch only
- o_valid  output  1  issue beat valid toward the aligner
- o_denorm_pp  output  4  issued partial product
- o_exp  output  6  issued exponent
- o_max_exp  output  6  batch maximum exponent, constant for all beats of the batch
- o_Q_frac  output  5  latched batch Q_frac
- o_last  output  1  final beat of the batch
- o_batch_done  output  1  one-cycle pulse after the last beat has left the aligner
- o_count  output  $clog2(NUM_PP)+1  entries in the current or last batch

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - State goes to COLLECT; write pointer, read pointer, max, count and drain counter clear.
  - All outputs are 0 except o_ready, which is 1.
  - Reset mid-batch discards all buffered entries; no o_batch_done is issued.
- State COLLECT:
  - o_ready=1; an entry is accepted on i_valid & o_ready.
  - Accepted entries are written to buffer[wptr]; wptr and count increment.
  - Running max: the first accepted entry loads max=i_exp; later entries use max = (i_exp > max) ? i_exp : max, an unsigned 6-bit compare.
  - Q_frac is latched on the first accepted entry only.
  - Batch closes when an accepted entry has i_last=1, or when the NUM_PP-th entry is accepted (forced close, i_last ignored). The closing entry is included in the max.
  - Next state on close: ISSUE.
  - o_ready drops to 0 in the cycle after the accepting edge; no entry is accepted while it is low.
  - o_valid stays 0 in COLLECT.
- State ISSUE:
  - o_ready=0; upstream i_valid is ignored and nothing is written.
  - Each cycle drives o_valid=1 with buffer[rptr], o_exp, o_max_exp and o_Q_frac from registers; rptr increments.
  - Beats are issued in arrival order with no bubbles; there is no backpressure.
  - Timing: the first beat is valid the cycle after the closing entry is accepted. Beat k (0-based) is valid at t+1+k, where t is the acceptance edge of the closing entry.
  - o_last=1 on beat count-1. After it: next state DRAIN, drain counter loaded with ALIGN_LAT.
- State DRAIN:
  - o_valid=0, o_ready=0; the counter decrements every cycle.
  - When the counter reaches 0: o_batch_done=1 for exactly one cycle and o_ready=1 in that same cycle. The state is COLLECT from that cycle on, with wptr, rptr and max cleared.
  - An entry may be accepted in the done cycle; it starts the next batch.
- o_count:
  - Holds the last batch size through ISSUE and DRAIN.
  - Clears on the first acceptance of the next batch.
- Single-entry batch: one beat with o_last=1 and o_max_exp=o_exp.
- Width and subtraction rules:
  - No exponent subtraction occurs in this block.
  - o_max_exp >= o_exp is guaranteed on every beat, so the aligner's max_exp - exp never wraps.
- Timing contract: all outputs are registered. The aligner's i_max_exp and max_exp inputs both connect to o_max_exp.

Test Plan:
- Reset then 4 entries, exp {3,7,5,7}, pp {4'h4,4'hC,4'h5,4'h7}, last on the 4th:
  - Beats 1 cycle later: exp 3,7,5,7, all with o_max_exp=7, in order.
  - o_last on beat 4.
  - o_batch_done 1 cycle after beat 4 (ALIGN_LAT=1).
  - o_count=4.
- 8 entries with i_last never asserted:
  - Forced close after the 8th; 8 beats; o_last on the 8th.
  - i_valid held high during ISSUE/DRAIN is not accepted (o_ready=0).
- Single entry exp=6'd63, last=1:
  - One beat with o_exp=o_max_exp=63 and o_last=1.
  - Done pulse follows; next batch's max restarts from its own first exp (e.g. 2 → 2).
- Q_frac changes mid-batch (5'd3 then 5'd9):
  - All beats carry o_Q_frac=3.
- Assert i_rst_n=0 during ISSUE beat 2 of 4:
  - Outputs immediately 0 and o_ready=1; no o_last or o_batch_done.
  - A fresh batch after release behaves normally.
- ALIGN_LAT=3, entry presented in the done cycle:
  - Done arrives 3 cycles after the last beat.
  - The entry offered in the done cycle is accepted and becomes beat 0 of the next batch.
